// File: rtl/adc_buf_pkg.sv
// Shared constants, FSM state type and skid entry layout for the ADC buffer readout.
package adc_buf_pkg;

    localparam int unsigned ADDR_BITS   = 13;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned ADDR_SPAN   = 4096;
    localparam int unsigned OFFSET_BITS = 12;
    localparam int unsigned CNT_BITS    = 13;

    localparam logic [ADDR_BITS-1:0] ADDR_START = 13'h800;
    localparam logic [ADDR_BITS-1:0] ADDR_END   = ADDR_START + ADDR_BITS'(ADDR_SPAN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } skid_entry_t;

endpackage

// File: rtl/adc_rd_skid.sv
// Two-entry FIFO that absorbs BRAM read data while the sink stalls.
module adc_rd_skid
    import adc_buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              push_last,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              head_last,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic [1:0]        count
);

    skid_entry_t mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count_q;

    // Storage, pointers and occupancy; pop is only issued by the owner when non-empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{last: push_last, data: push_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_last = mem[rd_ptr].last;
    assign head_data = mem[rd_ptr].data;
    assign count     = count_q;
    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);

endmodule

// File: rtl/adc_buf_reader.sv
// Streams the captured ADC buffer out of BRAM, starting at a software offset.
module adc_buf_reader
    import adc_buf_pkg::*;
(
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   cap_done_i,
    input  logic                   csr_rd_start_i,
    input  logic [OFFSET_BITS-1:0] csr_rd_offset_i,
    output logic                   csr_rd_busy_o,
    output logic                   csr_rd_done_o,
    output logic                   csr_rd_err_o,
    output logic                   mem_re_o,
    output logic [ADDR_BITS-1:0]   mem_addr_o,
    input  logic [DATA_W-1:0]      mem_data_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [DATA_W-1:0]      m_data_o,
    output logic                   m_last_o
);

    rd_state_t             state_q;
    rd_state_t             state_d;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [CNT_BITS-1:0]   issue_cnt_q;
    logic                  re_d_q;
    logic                  done_q;
    logic                  err_q;
    logic                  mem_re_c;

    logic                  skid_full;
    logic                  skid_empty;
    logic [1:0]            skid_count;
    logic                  head_last;
    logic [DATA_W-1:0]     head_data;
    logic                  pop;
    logic [2:0]            occ_after;
    logic                  issue_ok;

    // Occupancy after this cycle's pop plus the read whose data lands this cycle;
    // counting the pop keeps full throughput with the 2-entry skid.
    assign pop       = !skid_empty && m_ready_i;
    assign occ_after = 3'(skid_count) - 3'(pop) + 3'(re_d_q);
    assign issue_ok  = (occ_after < 3'd2) && !(skid_full && !pop);

    // FSM state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and read-issue decision.
    always_comb begin
        state_d  = state_q;
        mem_re_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (csr_rd_start_i && cap_done_i) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (issue_ok && (issue_cnt_q < CNT_BITS'(ADDR_SPAN))) begin
                    mem_re_c = 1'b1;
                end
                if (mem_re_c && (issue_cnt_q == CNT_BITS'(ADDR_SPAN - 1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address walk with wrap, issue counter, read pipeline tag and sticky status.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            addr_q      <= ADDR_START;
            issue_cnt_q <= '0;
            re_d_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            re_d_q <= mem_re_c;
            if ((state_q == IDLE) && csr_rd_start_i) begin
                done_q <= 1'b0;
                if (cap_done_i) begin
                    addr_q      <= ADDR_START + ADDR_BITS'(csr_rd_offset_i);
                    issue_cnt_q <= '0;
                    err_q       <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (mem_re_c) begin
                addr_q      <= (addr_q == ADDR_END) ? ADDR_START : addr_q + ADDR_BITS'(1);
                issue_cnt_q <= issue_cnt_q + CNT_BITS'(1);
            end
            if ((state_q == DRAIN) && pop && head_last) begin
                done_q <= 1'b1;
            end
        end
    end

    // Read data arrives one cycle after issue; the final issued read carries last.
    adc_rd_skid u_skid (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .push      (re_d_q),
        .push_last (issue_cnt_q == CNT_BITS'(ADDR_SPAN)),
        .push_data (mem_data_i),
        .pop       (pop),
        .head_last (head_last),
        .head_data (head_data),
        .full      (skid_full),
        .empty     (skid_empty),
        .count     (skid_count)
    );

    assign csr_rd_busy_o = (state_q != IDLE);
    assign csr_rd_done_o = done_q;
    assign csr_rd_err_o  = err_q;
    assign mem_re_o      = mem_re_c;
    assign mem_addr_o    = addr_q;
    assign m_valid_o     = !skid_empty;
    assign m_data_o      = head_data;
    assign m_last_o      = head_last;

endmodule
